cmd_parser: RTL

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/logip_pkg.sv | 29 ++
 rtl/id_responder.sv | 73 +++++++
 rtl/cmd_parser.sv | 134 +++++++++++++
 3 files changed

// File: rtl/logip_pkg.sv
// Shared definitions for the command parser: opcode map, reply FSM states
// and the default identification word.
package logip_pkg;

    // Identification reply, transmitted least-significant byte first ("1ALS").
    localparam logic [31:0] ID_WORD_DEF = 32'h534C4131;

    // Short opcodes (bit 7 clear, no argument).
    localparam logic [7:0] OPC_SRST  = 8'h00;
    localparam logic [7:0] OPC_ARM   = 8'h01;
    localparam logic [7:0] OPC_ID    = 8'h02;

    // Long opcodes (bit 7 set, 32-bit argument).
    localparam logic [7:0] OPC_DIV   = 8'h80;
    localparam logic [7:0] OPC_CNT   = 8'h81;
    localparam logic [7:0] OPC_FLAGS = 8'h82;

    // Trigger stage opcodes are 0b11ss_sskk: stage in [5:2], register in [1:0].
    localparam logic [1:0] STG_PREFIX   = 2'b11;
    localparam logic [1:0] STG_SEL_MASK = 2'd0;
    localparam logic [1:0] STG_SEL_VAL  = 2'd1;
    localparam logic [1:0] STG_SEL_CFG  = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } reply_state_e;

endpackage

// File: rtl/id_responder.sv
// Identification reply engine: streams the four bytes of ID_WORD to the
// UART transmitter with a valid/ready handshake, abortable by soft reset.
module id_responder
    import logip_pkg::*;
#(
    parameter logic [31:0] ID_WORD = ID_WORD_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       tx_rdy_i,
    output logic [7:0] tx_data_o,
    output logic       tx_stb_o,
    output logic       busy_o
);

    reply_state_e state_q, state_d;
    logic [1:0]   idx_q, idx_d;

    // Next-state: start only from IDLE, abort wins over a same-cycle accept.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SEND;
                    idx_d   = 2'd0;
                end
            end
            ST_SEND: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                end else if (tx_rdy_i) begin
                    if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State and byte index registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs depend only on registered state, so data holds while stalled.
    always_comb begin
        tx_stb_o  = (state_q == ST_SEND);
        busy_o    = (state_q == ST_SEND);
        tx_data_o = 8'h00;
        if (state_q == ST_SEND) begin
            tx_data_o = ID_WORD[{idx_q, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/cmd_parser.sv
// Host command decoder: turns opcode/argument strobes from the UART receiver
// into configuration registers and control pulses, and hands ID requests to
// the reply engine.
module cmd_parser
    import logip_pkg::*;
#(
    parameter int          STAGES  = 4,
    parameter logic [31:0] ID_WORD = ID_WORD_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            opc_i,
    input  logic [31:0]           cmd_i,
    input  logic                  stb_i,
    output logic                  srst_o,
    output logic                  arm_o,
    output logic [32*STAGES-1:0]  stg_mask_o,
    output logic [32*STAGES-1:0]  stg_val_o,
    output logic [32*STAGES-1:0]  stg_cfg_o,
    output logic [23:0]           div_o,
    output logic [15:0]           read_cnt_o,
    output logic [15:0]           dly_cnt_o,
    output logic [7:0]            flags_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_stb_o,
    input  logic                  tx_rdy_i,
    output logic                  busy_o
);

    // Packed per-stage arrays: element s lands at [32*s +: 32] of the flat port.
    logic [STAGES-1:0][31:0] mask_q, mask_d;
    logic [STAGES-1:0][31:0] val_q,  val_d;
    logic [STAGES-1:0][31:0] cfg_q,  cfg_d;
    logic [23:0]             div_q,  div_d;
    logic [15:0]             rcnt_q, rcnt_d;
    logic [15:0]             dcnt_q, dcnt_d;
    logic [7:0]              flags_q, flags_d;
    logic                    srst_q, srst_d;
    logic                    arm_q,  arm_d;

    logic id_start;
    logic id_abort;

    assign id_start = stb_i && (opc_i == OPC_ID);
    assign id_abort = stb_i && (opc_i == OPC_SRST);

    // Command decode; unknown opcodes and out-of-range stages leave state as is.
    always_comb begin
        mask_d  = mask_q;
        val_d   = val_q;
        cfg_d   = cfg_q;
        div_d   = div_q;
        rcnt_d  = rcnt_q;
        dcnt_d  = dcnt_q;
        flags_d = flags_q;
        srst_d  = 1'b0;
        arm_d   = 1'b0;
        if (stb_i) begin
            if (opc_i[7:6] == STG_PREFIX) begin
                for (int s = 0; s < STAGES; s++) begin
                    if (opc_i[5:2] == 4'(s)) begin
                        case (opc_i[1:0])
                            STG_SEL_MASK: mask_d[s] = cmd_i;
                            STG_SEL_VAL:  val_d[s]  = cmd_i;
                            STG_SEL_CFG:  cfg_d[s]  = cmd_i;
                            default: ;
                        endcase
                    end
                end
            end else begin
                case (opc_i)
                    OPC_SRST:  srst_d  = 1'b1;
                    OPC_ARM:   arm_d   = 1'b1;
                    OPC_DIV:   div_d   = cmd_i[23:0];
                    OPC_CNT: begin
                        rcnt_d = cmd_i[15:0];
                        dcnt_d = cmd_i[31:16];
                    end
                    OPC_FLAGS: flags_d = cmd_i[7:0];
                    default: ;
                endcase
            end
        end
    end

    // Configuration and pulse registers; reset also masks a same-cycle strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q  <= '0;
            val_q   <= '0;
            cfg_q   <= '0;
            div_q   <= '0;
            rcnt_q  <= '0;
            dcnt_q  <= '0;
            flags_q <= '0;
            srst_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            val_q   <= val_d;
            cfg_q   <= cfg_d;
            div_q   <= div_d;
            rcnt_q  <= rcnt_d;
            dcnt_q  <= dcnt_d;
            flags_q <= flags_d;
            srst_q  <= srst_d;
            arm_q   <= arm_d;
        end
    end

    assign stg_mask_o = mask_q;
    assign stg_val_o  = val_q;
    assign stg_cfg_o  = cfg_q;
    assign div_o      = div_q;
    assign read_cnt_o = rcnt_q;
    assign dly_cnt_o  = dcnt_q;
    assign flags_o    = flags_q;
    assign srst_o     = srst_q;
    assign arm_o      = arm_q;

    id_responder #(
        .ID_WORD (ID_WORD)
    ) u_id_responder (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (id_start),
        .abort_i   (id_abort),
        .tx_rdy_i  (tx_rdy_i),
        .tx_data_o (tx_data_o),
        .tx_stb_o  (tx_stb_o),
        .busy_o    (busy_o)
    );

endmodule
